sfa_cmd_issuer: RTL and testbench



---
 rtl/sfa_cmd_issuer.sv | 168 ++++++++++++++++
 tb/tb_sfa_cmd_issuer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sfa_cmd_issuer.sv
// sfa_cmd_issuer: host-side command initiator for one SFA tile control channel.
//   Takes one 32-bit command from the host stream, drives it onto the tile's sCMD port,
//   waits for the tile's single return word and forwards it (or a synthesized
//   {16'hDEAD, tag} word on timeout) to the host return stream. One command outstanding.
// Latency: host accept at N -> mCMD_tvalid at N+1; tile return at M -> mHostRet_tvalid at M+1.
// Backpressure: mCMD_tready / mHostRet_tready stall the FSM with data held stable; sRet_tready
//   is always 1, and returns arriving outside WAIT_RET are dropped and counted.
// Ports: ACLK/ARESET (sync, active-high); sHost_* host command in; mHostRet_* host return out;
//   mCMD_* command to tile; sRet_* return from tile; BUSY, CMD_COUNT, ERR_COUNT, STRAY_COUNT status.
// Build option: define SFA_CMD_TIMEOUT_EN to compile in the WAIT_RET timeout (TIMEOUT_CYCLES);
//   without it WAIT_RET waits forever and ERR_COUNT reads 0.
module sfa_cmd_issuer #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        ACLK,
    input  logic        ARESET,
    output logic        sHost_tready,
    input  logic        sHost_tvalid,
    input  logic [31:0] sHost_tdata,
    input  logic        mHostRet_tready,
    output logic        mHostRet_tvalid,
    output logic [31:0] mHostRet_tdata,
    input  logic        mCMD_tready,
    output logic        mCMD_tvalid,
    output logic [31:0] mCMD_tdata,
    output logic        sRet_tready,
    input  logic        sRet_tvalid,
    input  logic [31:0] sRet_tdata,
    output logic        BUSY,
    output logic [15:0] CMD_COUNT,
    output logic [7:0]  ERR_COUNT,
    output logic [7:0]  STRAY_COUNT
);

    // The timer is 16 bits, so the timeout must fit in it and allow at least one wait cycle.
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("sfa_cmd_issuer: TIMEOUT_CYCLES out of range 2..65535");
    end

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RET = 2'd2,
        SEND_RET = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] cmd_q;
    logic [31:0] ret_q;
    logic [15:0] cmd_cnt;
    logic [7:0]  stray_cnt;
    logic        cmd_ld;
    logic        ret_ld;
    logic        issue_fire;
    logic        stray;
    logic        timeout;

`ifdef SFA_CMD_TIMEOUT_EN
    localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] timer;
    logic [7:0]  err_cnt;
`endif

    always_comb begin
        state_nxt  = state;
        cmd_ld     = 1'b0;
        ret_ld     = 1'b0;
        issue_fire = 1'b0;
        timeout    = 1'b0;
        case (state)
            IDLE: begin
                if (sHost_tvalid) begin
                    cmd_ld    = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (mCMD_tready) begin
                    issue_fire = 1'b1;
                    state_nxt  = cmd_q[31] ? IDLE : WAIT_RET;
                end
            end
            WAIT_RET: begin
                // A return landing on the expiry cycle wins over the timeout.
                if (sRet_tvalid) begin
                    ret_ld    = 1'b1;
                    state_nxt = SEND_RET;
                end
`ifdef SFA_CMD_TIMEOUT_EN
                else if (timer == TIMER_LAST) begin
                    timeout   = 1'b1;
                    state_nxt = SEND_RET;
                end
`endif
            end
            SEND_RET: begin
                if (mHostRet_tready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Any return not expected is swallowed so a late tile answer never stalls the tile.
    assign stray = sRet_tvalid && (state != WAIT_RET);

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state     <= IDLE;
            cmd_q     <= '0;
            ret_q     <= '0;
            cmd_cnt   <= '0;
            stray_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (cmd_ld) begin
                cmd_q <= sHost_tdata;
            end
            if (ret_ld) begin
                ret_q <= sRet_tdata;
            end else if (timeout) begin
                ret_q <= {16'hDEAD, cmd_q[15:0]};
            end
            if (issue_fire) begin
                cmd_cnt <= cmd_cnt + 16'd1;
            end
            if (stray && stray_cnt != 8'hFF) begin
                stray_cnt <= stray_cnt + 8'd1;
            end
        end
    end

`ifdef SFA_CMD_TIMEOUT_EN
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            timer   <= '0;
            err_cnt <= '0;
        end else begin
            if (issue_fire) begin
                timer <= '0;
            end else if (state == WAIT_RET) begin
                timer <= timer + 16'd1;
            end
            if (timeout && err_cnt != 8'hFF) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

    assign ERR_COUNT = err_cnt;
`else
    assign ERR_COUNT = 8'd0;
`endif

    // All outputs decode from registered state; no input-to-output paths.
    assign sHost_tready    = (state == IDLE);
    assign mCMD_tvalid     = (state == ISSUE);
    assign mCMD_tdata      = cmd_q;
    assign mHostRet_tvalid = (state == SEND_RET);
    assign mHostRet_tdata  = ret_q;
    assign sRet_tready     = 1'b1;
    assign BUSY            = (state != IDLE);
    assign CMD_COUNT       = cmd_cnt;
    assign STRAY_COUNT     = stray_cnt;

endmodule

// File: tb/tb_sfa_cmd_issuer.sv
// Bench for sfa_cmd_issuer: table of single-transaction scenarios, hand-written stray and
// reset sequences, then a randomized run against a transaction-level scoreboard.
module tb_sfa_cmd_issuer;

    localparam int T = 8;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic        sHost_tready;
    logic        sHost_tvalid;
    logic [31:0] sHost_tdata;
    logic        mHostRet_tready;
    logic        mHostRet_tvalid;
    logic [31:0] mHostRet_tdata;
    logic        mCMD_tready;
    logic        mCMD_tvalid;
    logic [31:0] mCMD_tdata;
    logic        sRet_tready;
    logic        sRet_tvalid;
    logic [31:0] sRet_tdata;
    logic        BUSY;
    logic [15:0] CMD_COUNT;
    logic [7:0]  ERR_COUNT;
    logic [7:0]  STRAY_COUNT;

    sfa_cmd_issuer #(.TIMEOUT_CYCLES(T)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .sHost_tready(sHost_tready), .sHost_tvalid(sHost_tvalid), .sHost_tdata(sHost_tdata),
        .mHostRet_tready(mHostRet_tready), .mHostRet_tvalid(mHostRet_tvalid),
        .mHostRet_tdata(mHostRet_tdata),
        .mCMD_tready(mCMD_tready), .mCMD_tvalid(mCMD_tvalid), .mCMD_tdata(mCMD_tdata),
        .sRet_tready(sRet_tready), .sRet_tvalid(sRet_tvalid), .sRet_tdata(sRet_tdata),
        .BUSY(BUSY), .CMD_COUNT(CMD_COUNT), .ERR_COUNT(ERR_COUNT), .STRAY_COUNT(STRAY_COUNT)
    );

    always #5 ACLK = ~ACLK;

    int checks = 0;
    int errors = 0;
    int exp_cmd = 0;
    int exp_err = 0;
    int exp_stray = 0;

    typedef struct {
        logic [31:0] cmd;
        int          cmd_stall;
        int          ret_delay;   // cycles after WAIT_RET entry before the tile answers
        logic [31:0] ret_word;
        int          host_stall;
        int          exp_lat;     // WAIT_RET entry to SEND_RET entry, in cycles
        logic [31:0] exp_ret;
        int          exp_err;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    task automatic drive_quiet();
        sHost_tvalid    = 1'b0;
        sHost_tdata     = 32'h0;
        mHostRet_tready = 1'b0;
        mCMD_tready     = 1'b0;
        sRet_tvalid     = 1'b0;
        sRet_tdata      = 32'h0;
    endtask

    task automatic check_counters(input string tag);
        chk({tag, "_cmd_count"}, 32'(CMD_COUNT), 32'(exp_cmd % 65536));
        chk({tag, "_err_count"}, 32'(ERR_COUNT), 32'(exp_err > 255 ? 255 : exp_err));
        chk({tag, "_stray_count"}, 32'(STRAY_COUNT), 32'(exp_stray > 255 ? 255 : exp_stray));
    endtask

    task automatic do_txn(input vec_t v);
        bit got;
        int lat;
        chk("idle_busy", 32'(BUSY), 32'd0);
        chk("idle_host_rdy", 32'(sHost_tready), 32'd1);
        sHost_tvalid = 1'b1;
        sHost_tdata  = v.cmd;
        step();
        sHost_tvalid = 1'b0;
        sHost_tdata  = $urandom;
        chk("issue_vld", 32'(mCMD_tvalid), 32'd1);
        chk("issue_dat", mCMD_tdata, v.cmd);
        chk("issue_busy", 32'(BUSY), 32'd1);
        for (int i = 0; i < v.cmd_stall; i++) begin
            step();
            chk("issue_hold_vld", 32'(mCMD_tvalid), 32'd1);
            chk("issue_hold_dat", mCMD_tdata, v.cmd);
            chk("issue_host_rdy", 32'(sHost_tready), 32'd0);
        end
        chk("issue_sret_rdy", 32'(sRet_tready), 32'd1);
        mCMD_tready = 1'b1;
        step();
        mCMD_tready = 1'b0;
        exp_cmd++;
        if (v.cmd[31]) begin
            chk("noret_idle", 32'(BUSY), 32'd0);
            chk("noret_cmd_vld", 32'(mCMD_tvalid), 32'd0);
            chk("noret_ret_vld", 32'(mHostRet_tvalid), 32'd0);
            check_counters("noret");
            return;
        end
        chk("wait_no_reissue", 32'(mCMD_tvalid), 32'd0);
        got = 1'b0;
        lat = 0;
        for (int k = 0; k < 3000 && !got; k++) begin
            if (k == v.ret_delay) begin
                sRet_tvalid = 1'b1;
                sRet_tdata  = v.ret_word;
            end
            step();
            sRet_tvalid = 1'b0;
            if (mHostRet_tvalid) begin
                got = 1'b1;
                lat = k + 1;
            end
        end
        chk("ret_latency", 32'(lat), 32'(v.exp_lat));
        if (!got) begin
            return;
        end
        chk("ret_dat", mHostRet_tdata, v.exp_ret);
        for (int i = 0; i < v.host_stall; i++) begin
            step();
            chk("ret_hold_vld", 32'(mHostRet_tvalid), 32'd1);
            chk("ret_hold_dat", mHostRet_tdata, v.exp_ret);
        end
        mHostRet_tready = 1'b1;
        step();
        mHostRet_tready = 1'b0;
        chk("done_busy", 32'(BUSY), 32'd0);
        chk("done_ret_vld", 32'(mHostRet_tvalid), 32'd0);
        exp_err += v.exp_err;
        check_counters("txn");
    endtask

    task automatic random_run();
        logic [31:0] cmdq[$];
        logic [31:0] retq[$];
        logic [31:0] host_word;
        logic [31:0] tret_word;
        logic [31:0] w;
        bit host_pend = 1'b0;
        bit tret_pend = 1'b0;
        bit stray_now;
        int tret_cnt = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (!host_pend && cyc < 3500 && $urandom_range(0, 2) == 0) begin
                host_pend     = 1'b1;
                host_word     = $urandom;
                host_word[31] = ($urandom_range(0, 3) == 0);
            end
            sHost_tvalid    = host_pend;
            sHost_tdata     = host_pend ? host_word : 32'h0;
            mCMD_tready     = 1'($urandom_range(0, 1));
            mHostRet_tready = ($urandom_range(0, 2) != 0);
            sRet_tvalid     = 1'b0;
            stray_now       = 1'b0;
            if (tret_pend && tret_cnt == 0) begin
                sRet_tvalid = 1'b1;
                sRet_tdata  = tret_word;
            end else if (!tret_pend && !BUSY && $urandom_range(0, 15) == 0) begin
                sRet_tvalid = 1'b1;
                sRet_tdata  = $urandom;
                stray_now   = 1'b1;
            end
            #1;
            if (sHost_tvalid && sHost_tready) begin
                cmdq.push_back(host_word);
                host_pend = 1'b0;
            end
            if (sRet_tvalid && sRet_tready) begin
                if (stray_now) exp_stray++;
                else begin
                    retq.push_back(tret_word);
                    tret_pend = 1'b0;
                end
            end else if (tret_pend && tret_cnt > 0) begin
                tret_cnt--;
            end
            if (mCMD_tvalid && mCMD_tready) begin
                if (cmdq.size() == 0) chk("rnd_spurious_cmd", 32'd1, 32'd0);
                else begin
                    w = cmdq.pop_front();
                    chk("rnd_cmd_dat", mCMD_tdata, w);
                    exp_cmd++;
                    if (!w[31]) begin
                        tret_pend = 1'b1;
                        tret_cnt  = $urandom_range(0, T - 1);
                        tret_word = $urandom;
                    end
                end
            end
            if (mHostRet_tvalid && mHostRet_tready) begin
                if (retq.size() == 0) chk("rnd_spurious_ret", 32'd1, 32'd0);
                else chk("rnd_ret_dat", mHostRet_tdata, retq.pop_front());
            end
            @(posedge ACLK);
            #1;
        end
        drive_quiet();
        chk("rnd_cmdq_empty", 32'(cmdq.size()), 32'd0);
        chk("rnd_retq_empty", 32'(retq.size()), 32'd0);
        chk("rnd_host_drained", 32'(host_pend), 32'd0);
        chk("rnd_tile_drained", 32'(tret_pend), 32'd0);
        chk("rnd_busy", 32'(BUSY), 32'd0);
        check_counters("rnd");
    endtask

    initial begin
        vecs[0] = '{32'h0001_0005, 0, 3, 32'h0000_00AA, 0, 4, 32'h0000_00AA, 0};
        vecs[1] = '{32'h8000_0007, 0, 0, 32'h0, 0, 0, 32'h0, 0};
        vecs[2] = '{32'h0000_0042, 5, 1, 32'h1234_5678, 4, 2, 32'h1234_5678, 0};
        vecs[3] = '{32'h0000_0077, 0, T - 1, 32'hBEEF_0001, 0, T, 32'hBEEF_0001, 0};
`ifdef SFA_CMD_TIMEOUT_EN
        vecs[4] = '{32'h0000_1234, 0, 9999, 32'h0, 2, T, 32'hDEAD_1234, 1};
`else
        vecs[4] = '{32'h0000_1234, 0, 2000, 32'hCAFE_F00D, 1, 2001, 32'hCAFE_F00D, 0};
`endif
        vecs[5] = '{32'h8000_FFFF, 3, 0, 32'h0, 0, 0, 32'h0, 0};
        vecs[6] = '{32'h0000_5555, 2, 0, 32'h0F0F_0F0F, 1, 1, 32'h0F0F_0F0F, 0};

        drive_quiet();
        ARESET = 1'b1;
        repeat (3) step();
        ARESET = 1'b0;
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_host_rdy", 32'(sHost_tready), 32'd1);
        chk("rst_sret_rdy", 32'(sRet_tready), 32'd1);
        chk("rst_cmd_vld", 32'(mCMD_tvalid), 32'd0);
        chk("rst_ret_vld", 32'(mHostRet_tvalid), 32'd0);
        chk("rst_cmd_dat", mCMD_tdata, 32'h0);
        chk("rst_ret_dat", mHostRet_tdata, 32'h0);
        check_counters("rst");

        for (int i = 0; i < 7; i++) begin
            do_txn(vecs[i]);
        end

        // Late/stray return while idle: dropped and counted.
        sRet_tvalid = 1'b1;
        sRet_tdata  = 32'h5A5A_1234;
        chk("stray_rdy", 32'(sRet_tready), 32'd1);
        step();
        sRet_tvalid = 1'b0;
        exp_stray++;
        chk("stray_busy", 32'(BUSY), 32'd0);
        chk("stray_ret_vld", 32'(mHostRet_tvalid), 32'd0);
        check_counters("stray");

        // Reset while waiting for a return.
        sHost_tvalid = 1'b1;
        sHost_tdata  = 32'h0000_0099;
        step();
        sHost_tvalid = 1'b0;
        mCMD_tready  = 1'b1;
        step();
        mCMD_tready  = 1'b0;
        chk("wr_busy", 32'(BUSY), 32'd1);
        ARESET = 1'b1;
        step();
        ARESET = 1'b0;
        exp_cmd = 0;
        exp_err = 0;
        exp_stray = 0;
        chk("wr_busy_after", 32'(BUSY), 32'd0);
        chk("wr_host_rdy", 32'(sHost_tready), 32'd1);
        chk("wr_cmd_vld", 32'(mCMD_tvalid), 32'd0);
        chk("wr_ret_vld", 32'(mHostRet_tvalid), 32'd0);
        chk("wr_ret_dat", mHostRet_tdata, 32'h0);
        check_counters("wr");
        repeat (T + 2) step();
        chk("wr_no_late_ret", 32'(mHostRet_tvalid), 32'd0);
        chk("wr_still_idle", 32'(BUSY), 32'd0);

        random_run();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
